// File: rtl/unidade_logica_nbits_if.sv
// Purpose: operand/result handshake bundle for unidade_logica_nbits.
// Signals:
//   in_valid/in_ready    - operand beat handshake (master -> unit)
//   op, a, b             - operation select and operands
//   out_valid/out_ready  - result beat handshake (unit -> master)
//   s, flag_zero, flag_par - result and flags
// Modports: master (operand source / result sink), slave (the logic unit).
interface unidade_logica_nbits_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             flag_zero;
  logic             flag_par;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, s, flag_zero, flag_par
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, s, flag_zero, flag_par
  );
endinterface

// File: rtl/unidade_logica_nbits.sv
// Purpose: two-stage pipelined WIDTH-bit logic unit (NOT/AND/OR/XOR/NAND/NOR/
//          XNOR/PASS) with valid/ready on both sides, zero/parity flags and a
//          wrapping count of delivered results.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset; flushes the pipeline
//   bus       - unidade_logica_nbits_if.slave (operands in, result/flags out)
//   op_count  - results consumed downstream, modulo 2^CNT_W
// Build option: UNIDADE_LOGICA_PARIDADE_EN enables the registered parity flag;
//   when undefined flag_par is tied low. The port list is the same either way.
module unidade_logica_nbits #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  unidade_logica_nbits_if.slave bus,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // Pipeline occupancy encoded as {v2, v1}.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    S1_ONLY = 2'b01,
    S2_ONLY = 2'b10,
    FULL    = 2'b11
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             v1;
  logic             v2;
  logic             v1_next;
  logic             v2_next;
  logic             load1;
  logic             load2;
  logic             deliver;
  logic             in_ready_c;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] s_q;
  logic             zero_q;
  logic             par_q;

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Handshake decode and next occupancy.
  always_comb begin
    v1         = state[0];
    v2         = state[1];
    load2      = 1'b0;
    deliver    = 1'b0;
    in_ready_c = 1'b0;
    load1      = 1'b0;
    v1_next    = v1;
    v2_next    = v2;
    state_next = state;

    load2      = v1 && (!v2 || bus.out_ready);
    deliver    = v2 && bus.out_ready;
    // rst_n term keeps in_ready low throughout reset; out_ready feeds through.
    in_ready_c = rst_n && (!v1 || !v2 || bus.out_ready);
    load1      = bus.in_valid && in_ready_c;

    if (load1)      v1_next = 1'b1;
    else if (load2) v1_next = 1'b0;

    if (load2)        v2_next = 1'b1;
    else if (deliver) v2_next = 1'b0;

    state_next = state_t'({v2_next, v1_next});
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_NOT;
      a_q  <= '0;
      b_q  <= '0;
    end else if (load1) begin
      op_q <= bus.op;
      a_q  <= bus.a;
      b_q  <= bus.b;
    end
  end

  // Logic operation on the stage-1 operands.
  always_comb begin
    res_c = '0;
    case (op_q)
      OP_NOT:  res_c = ~a_q;
      OP_AND:  res_c = a_q & b_q;
      OP_OR:   res_c = a_q | b_q;
      OP_XOR:  res_c = a_q ^ b_q;
      OP_NAND: res_c = ~(a_q & b_q);
      OP_NOR:  res_c = ~(a_q | b_q);
      OP_XNOR: res_c = ~(a_q ^ b_q);
      OP_PASS: res_c = a_q;
      default: res_c = '0;
    endcase
  end

  // Stage 2: result and zero flag; held until delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      zero_q <= 1'b0;
    end else if (load2) begin
      s_q    <= res_c;
      zero_q <= ~|res_c;
    end
  end

`ifdef UNIDADE_LOGICA_PARIDADE_EN
  // Stage 2 parity, registered with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     par_q <= 1'b0;
    else if (load2) par_q <= ^res_c;
  end
`else
  assign par_q = 1'b0;
`endif

  // Delivered-result counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       op_count <= '0;
    else if (deliver) op_count <= op_count + CNT_W'(1);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v2;
  assign bus.s         = s_q;
  assign bus.flag_zero = zero_q;
  assign bus.flag_par  = par_q;

endmodule

// File: tb/tb_unidade_logica_nbits.sv
// Purpose: scoreboard bench for unidade_logica_nbits (WIDTH=8, CNT_W=4).
// The driver pushes the hand-computed result of each accepted beat; a negedge
// monitor compares whatever the unit presents against the queue front.
module tb_unidade_logica_nbits;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             z;
    logic             p;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] op_count;

  exp_t             sb[$];
  int               dcyc[$];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               stalls = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unidade_logica_nbits_if #(.WIDTH(WIDTH)) bus ();

  unidade_logica_nbits #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .op_count (op_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] s);
    exp_t e;
    e.s = s;
    e.z = (s == '0);
`ifdef UNIDADE_LOGICA_PARIDADE_EN
    e.p = ^s;
`else
    e.p = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: compare presented result, and on delivery the counter as well.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(bus.s), 64'hDEAD);
      end else begin
        check("s", 64'(bus.s), 64'(sb[0].s));
        check("flag_zero", 64'(bus.flag_zero), 64'(sb[0].z));
        check("flag_par", 64'(bus.flag_par), 64'(sb[0].p));
        if (bus.out_ready) begin
          check("op_count_pre", 64'(op_count), 64'(exp_cnt));
          exp_cnt = exp_cnt + CNT_W'(1);
          void'(sb.pop_front());
          dcyc.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] es);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) begin
      check("send_timeout", 64'(w), 64'd0);
      bus.in_valid = 1'b0;
      return;
    end
    stalls += w;
    @(posedge clk);
    sb.push_back(mk(es));
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w >= 100) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    exp_cnt = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_s", 64'(bus.s), 64'd0);
    check("rst_zero", 64'(bus.flag_zero), 64'd0);
    check("rst_par", 64'(bus.flag_par), 64'd0);
    check("rst_count", 64'(op_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // NOT 0x5A -> 0xA5, two edges from being presented to out_valid.
    send(3'b000, 8'h5A, 8'h00, 8'hA5);
    @(negedge clk);
    check("lat_s1_only", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_s2_valid", 64'(bus.out_valid), 64'd1);
    drain();
    check("not_count", 64'(op_count), 64'd1);

    // Streaming AND / OR / NOR.
    stalls = 0;
    send(3'b001, 8'hF0, 8'h3C, 8'h30);
    send(3'b010, 8'hF0, 8'h0F, 8'hFF);
    send(3'b101, 8'hF0, 8'h0F, 8'h00);
    drain();
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_back2back", 64'(dcyc[dcyc.size()-1] - dcyc[dcyc.size()-3]), 64'd2);
    check("stream_count", 64'(op_count), 64'd4);

    // Backpressure: two beats buffer, then in_ready falls.
    bus.out_ready = 1'b0;
    send(3'b011, 8'hAA, 8'hAA, 8'h00);
    send(3'b110, 8'h00, 8'hFF, 8'h00);
    bus.in_valid = 1'b1;
    bus.op = 3'b111;
    bus.a  = 8'h77;
    @(negedge clk);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check("bp_s_hold", 64'(bus.s), 64'd0);
    check("bp_zero_hold", 64'(bus.flag_zero), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    check("bp_count", 64'(op_count), 64'd6);

    // Counter wrap with CNT_W=4: 17 deliveries from a fresh reset.
    do_reset();
    for (int i = 0; i < 17; i++) send(3'b111, 8'(i + 1), 8'h00, 8'(i + 1));
    drain();
    check("wrap_count_17", 64'(op_count), 64'd1);

    // Asynchronous reset with two beats buffered.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(3'b111, 8'h11, 8'h00, 8'h11);
    send(3'b111, 8'h22, 8'h00, 8'h22);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    exp_cnt = '0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_s", 64'(bus.s), 64'd0);
    check("mid_rst_count", 64'(op_count), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(3'b111, 8'h3C, 8'h00, 8'h3C);
    drain();
    check("post_rst_count", 64'(op_count), 64'd1);

    // Parity flag on PASS 0x01 (zero unless the parity build is enabled).
    send(3'b111, 8'h01, 8'h00, 8'h01);
    drain();
    check("par_count", 64'(op_count), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
